fixed_point_divider: RTL and testbench

- Sequential signed fixed-point divider; the inverse of the team's combinational fixed-point multiplier.
- Computes a_i / b_i for Q-format operands with InPoint fractional bits and returns a quotient with OutPoint fractional bits.
- Uses restoring division, one quotient bit per cycle, with valid/ready handshakes on both sides.
- Used by the jpeg2k normalisation and quantiser-step paths where a runtime divisor is needed.

---
 rtl/fixed_point_pkg.sv | 43 ++++
 rtl/fixed_point_divider_if.sv | 28 ++
 rtl/fixed_point_divider.sv | 142 ++++++++++++++
 tb/tb_fixed_point_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point constants, divider state encoding and a saturation helper
// used by both the divider and the multiplier paths.
package fixed_point_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int IN_POINT_DEF  = 10;
  localparam int OUT_POINT_DEF = 10;

  // Widest magnitude the saturation helper accepts; callers zero-extend into it.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] value;
    logic                 overflow;
  } sat_result_t;

  // Applies the sign to an unsigned magnitude and clamps to a width-bit signed
  // range; the caller keeps value[width-1:0].
  function automatic sat_result_t saturate(input logic [SAT_MAX_W-1:0] mag,
                                           input logic                 neg,
                                           input int unsigned          width);
    logic [SAT_MAX_W-1:0] lim;
    sat_result_t          res;
    lim          = SAT_MAX_W'(1) << (width - 1);
    res.value    = neg ? (~mag + SAT_MAX_W'(1)) : mag;
    res.overflow = 1'b0;
    if (!neg && (mag > (lim - SAT_MAX_W'(1)))) begin
      res.value    = lim - SAT_MAX_W'(1);
      res.overflow = 1'b1;
    end else if (neg && (mag > lim)) begin
      res.value    = ~lim + SAT_MAX_W'(1);
      res.overflow = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for the sequential fixed-point divider.
interface fixed_point_divider_if
  import fixed_point_pkg::*;
#(
  parameter int Width = WIDTH_DEF
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [Width-1:0] a_i;
  logic [Width-1:0] b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [Width-1:0] q_o;
  logic             overflow_o;
  logic             div_zero_o;

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, q_o, overflow_o, div_zero_o
  );

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, q_o, overflow_o, div_zero_o
  );

endinterface

// File: rtl/fixed_point_divider.sv
// Signed fixed-point restoring divider: one quotient bit per cycle, result
// saturated to Width bits with OutPoint fractional bits.
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int Width    = WIDTH_DEF,
  parameter int InPoint  = IN_POINT_DEF,
  parameter int OutPoint = OUT_POINT_DEF
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  fixed_point_divider_if.slave dif
);

  // a and b share InPoint fraction bits which cancel, so only OutPoint remains.
  localparam int ScaleShift = OutPoint + InPoint - InPoint;
  localparam int N          = Width + ScaleShift;
  localparam int CntW       = $clog2(N);

  localparam logic [Width-1:0] QMax = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] QMin = {1'b1, {(Width-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width:0]   rem_q, rem_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [Width-1:0] div_q, div_d;
  logic             sign_q, sign_d;
  logic [Width-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [Width-1:0] a_mag, b_mag;
  logic [Width:0]   rem_shift, rem_sub;
  logic             q_bit;
  logic [N-1:0]     quo_next;
  sat_result_t      sat_res;
  logic             unused_bits;

  assign a_neg = dif.a_i[Width-1];
  assign b_neg = dif.b_i[Width-1];
  // Plain two's-complement negate: |-2^(W-1)| lands on 2^(W-1) as unsigned.
  assign a_mag = a_neg ? (~dif.a_i + Width'(1)) : dif.a_i;
  assign b_mag = b_neg ? (~dif.b_i + Width'(1)) : dif.b_i;

  // The remainder stays below |b|, so its top bit never carries information.
  assign unused_bits = ^{sat_res.value[SAT_MAX_W-1:Width], rem_q[Width], quo_q[N-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    div_d   = div_q;
    sign_d  = sign_q;
    q_d     = q_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    rem_shift = {rem_q[Width-1:0], dvd_q[N-1]};
    rem_sub   = rem_shift - {1'b0, div_q};
    q_bit     = (rem_shift >= {1'b0, div_q});
    quo_next  = {quo_q[N-2:0], q_bit};
    sat_res   = saturate(SAT_MAX_W'(quo_next), sign_q, Width);

    unique case (state_q)
      IDLE: begin
        if (dif.in_valid_i) begin
          sign_d = a_neg ^ b_neg;
          div_d  = b_mag;
          dvd_d  = {a_mag, {ScaleShift{1'b0}}};
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = CntW'(N - 1);
          if (b_mag == '0) begin
            state_d = DONE;
            q_d     = a_neg ? QMin : QMax;
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = q_bit ? rem_sub : rem_shift;
        dvd_d = dvd_q << 1;
        quo_d = quo_next;
        if (cnt_q == '0) begin
          state_d = DONE;
          q_d     = sat_res.value[Width-1:0];
          ovf_d   = sat_res.overflow;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE: begin
        if (dif.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      sign_q  <= 1'b0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      sign_q  <= sign_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign dif.in_ready_o  = (state_q == IDLE);
  assign dif.out_valid_o = (state_q == DONE);
  assign dif.q_o         = q_q;
  assign dif.overflow_o  = ovf_q;
  assign dif.div_zero_o  = dz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench: directed cases plus random operands against an
// integer-arithmetic model of the signed fixed-point quotient.
module tb_fixed_point_divider;
  import fixed_point_pkg::*;

  localparam int W  = WIDTH_DEF;
  localparam int OP = OUT_POINT_DEF;
  localparam int N  = W + OP;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fixed_point_divider_if #(.Width(W)) dif ();

  fixed_point_divider #(
    .Width   (W),
    .InPoint (IN_POINT_DEF),
    .OutPoint(OP)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .dif    (dif)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact rational quotient truncated toward zero, then clamped.
  task automatic model(input int a, input int b, output int q, output bit ovf, output bit dz);
    longint num, quo;
    ovf = 1'b0;
    dz  = 1'b0;
    if (b == 0) begin
      dz = 1'b1;
      q  = (a < 0) ? -32768 : 32767;
    end else begin
      num = longint'(a) * (longint'(1) << OP);
      quo = num / longint'(b);
      if (quo > 32767) begin
        q   = 32767;
        ovf = 1'b1;
      end else if (quo < -32768) begin
        q   = -32768;
        ovf = 1'b1;
      end else begin
        q = int'(quo);
      end
    end
  endtask

  task automatic issue(input int a, input int b);
    logic [W-1:0] junk_a, junk_b;
    dif.in_valid_i = 1'b1;
    dif.a_i        = a[W-1:0];
    dif.b_i        = b[W-1:0];
    @(posedge clk);
    #1;
    junk_a         = W'($urandom);
    junk_b         = W'($urandom);
    dif.in_valid_i = 1'b0;
    dif.a_i        = junk_a;
    dif.b_i        = junk_b;
  endtask

  // Counts edges from the accept edge (edge 1) until out_valid_o is seen.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!dif.out_valid_o && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("valid_timeout", dif.out_valid_o, 1);
  endtask

  task automatic retire();
    dif.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready_i = 1'b0;
    check_val("retire_valid", dif.out_valid_o, 0);
    check_val("retire_ready", dif.in_ready_o, 1);
  endtask

  task automatic run_div(input int a, input int b, input int hold);
    int q_exp;
    bit ovf_exp, dz_exp;
    int cyc;
    model(a, b, q_exp, ovf_exp, dz_exp);
    check_val("in_ready_idle", dif.in_ready_o, 1);
    issue(a, b);
    check_val("in_ready_after_accept", dif.in_ready_o, 0);
    wait_valid(cyc);
    check_val("latency", cyc, (b == 0) ? 1 : N + 1);
    check_val("q", $signed(dif.q_o), q_exp);
    check_val("overflow", dif.overflow_o, ovf_exp);
    check_val("div_zero", dif.div_zero_o, dz_exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", dif.out_valid_o, 1);
      check_val("hold_ready", dif.in_ready_o, 0);
      check_val("hold_q", $signed(dif.q_o), q_exp);
    end
    $display("div a=%0d b=%0d q=%0d ovf=%0b dz=%0b lat=%0d exp_q=%0d",
             a, b, $signed(dif.q_o), dif.overflow_o, dif.div_zero_o, cyc, q_exp);
    retire();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          a, b;
    logic [15:0] r;

    rst_n           = 1'b0;
    dif.in_valid_i  = 1'b0;
    dif.out_ready_i = 1'b0;
    dif.a_i         = '0;
    dif.b_i         = '0;
    #1;
    check_val("rst_in_ready", dif.in_ready_o, 1);
    check_val("rst_out_valid", dif.out_valid_o, 0);
    check_val("rst_q", dif.q_o, 0);
    check_val("rst_overflow", dif.overflow_o, 0);
    check_val("rst_div_zero", dif.div_zero_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_div(3072, 1024, 0);
    run_div(1024, 3072, 0);
    run_div(-1024, 3072, 0);
    run_div(32767, 1, 0);
    run_div(-32768, 1, 0);
    run_div(-5, 0, 0);
    run_div(0, 0, 0);
    run_div(-32768, -32768, 0);
    run_div(-32, 1, 2);

    // Back-pressure with a new request queued during DONE
    issue(3072, 1024);
    wait_valid(cyc);
    check_val("bp_latency", cyc, N + 1);
    dif.in_valid_i = 1'b1;
    dif.a_i        = 16'd2048;
    dif.b_i        = 16'd1024;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_val("bp_valid", dif.out_valid_o, 1);
      check_val("bp_in_ready", dif.in_ready_o, 0);
      check_val("bp_q", $signed(dif.q_o), 3072);
    end
    $display("div a=3072 b=1024 held 10 cycles q=%0d", $signed(dif.q_o));
    dif.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready_i = 1'b0;
    check_val("bp_retired", dif.out_valid_o, 0);
    check_val("bp_ready_again", dif.in_ready_o, 1);
    @(posedge clk);
    #1;
    dif.in_valid_i = 1'b0;
    check_val("bp_queued_accepted", dif.in_ready_o, 0);
    wait_valid(cyc);
    check_val("bp_queued_latency", cyc, N + 1);
    check_val("bp_queued_q", $signed(dif.q_o), 2048);
    $display("div a=2048 b=1024 (queued) q=%0d lat=%0d", $signed(dif.q_o), cyc);
    retire();

    // Reset abort while BUSY at counter 5
    issue(5120, 1024);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_in_ready", dif.in_ready_o, 1);
    check_val("abort_out_valid", dif.out_valid_o, 0);
    check_val("abort_q", dif.q_o, 0);
    check_val("abort_overflow", dif.overflow_o, 0);
    check_val("abort_div_zero", dif.div_zero_o, 0);
    $display("reset abort during BUSY, outputs q=%0d valid=%0b", dif.q_o, dif.out_valid_o);
    @(posedge clk);
    #1;
    check_val("abort_no_emit", dif.out_valid_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_div(2048, 1024, 0);

    for (int t = 0; t < 40; t++) begin
      r = 16'($urandom);
      a = int'($signed(r));
      case ($urandom_range(0, 9))
        0: b = 0;
        1, 2, 3, 4: b = int'($urandom_range(0, 4096)) - 2048;
        default: begin
          r = 16'($urandom);
          b = int'($signed(r));
        end
      endcase
      run_div(a, b, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
